sn74145_scan_ctrl: RTL and testbench
====================================

// Module: sn74145_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for one shared SN74145 BCD-to-decimal decoder driving N digit positions.
//  Cycles through the digits: drives each BCD nibble to decoder inputs a..d and asserts one active-low digit select.
//  A blanking gap between digits prevents ghosting. New values take effect only at frame boundaries (no tearing).
//  Sits between the register/display-value logic and the decoder's i_a..i_d / i_cs inputs.
// PARAMETERS
//  N_DIGITS   4     number of multiplexed digits, legal 1..8
//  DWELL_CYC  1000  clock cycles each digit is lit, legal >=1
//  BLANK_CYC  16    clock cycles all digits dark before each digit, legal >=1
// PORTS
//  i_clk        in   1           system clock, rising edge
//  i_rst        in   1           synchronous reset, active-high
//  i_en         in   1           scan enable; low forces IDLE
//  i_load       in   1           1-cycle strobe: capture i_digits into pending register
//  i_digits     in   4*N_DIGITS  packed BCD; nibble k = digit k, digit 0 = LSB/rightmost
//  o_a,o_b,o_c,o_d out 1 each    BCD code to decoder (o_a = LSB)
//  o_cs         out  1           decoder enable, high while a digit is lit
//  o_dig_n      out  N_DIGITS    one-hot active-low digit select
//  o_pending    out  1           load captured, not yet applied to display
//  o_frame_done out  1           1-cycle pulse at end of last digit's dwell
// BEHAVIOUR
//  - All outputs registered. Reset values: {o_d,o_c,o_b,o_a}=4'hF (blank code), o_cs=0, o_dig_n=all 1s, o_pending=0, o_frame_done=0.
//    Reset state=IDLE, index=0, display and pending registers = all 4'hF.
//  - FSM states IDLE, BLANK, ON. Sole counter: dwell/blank count, width clog2(max(DWELL_CYC,BLANK_CYC)).
//    IDLE: outputs blanked; i_en=1 -> BLANK, index=0, count cleared.
//    BLANK: o_cs=0, o_dig_n all 1, code 4'hF. Lasts exactly BLANK_CYC cycles, then -> ON.
//    ON: o_cs=1, o_dig_n[index]=0, code = display nibble[index]. Lasts exactly DWELL_CYC cycles, then -> BLANK.
//      On ON exit the index increments; it wraps N_DIGITS-1 -> 0.
//  - Frame length = N_DIGITS*(BLANK_CYC+DWELL_CYC) cycles. o_frame_done pulses on the cycle the FSM leaves ON for index N_DIGITS-1.
//  - Load handshake:
//    i_load sets pending = i_digits and o_pending=1. A second load before the boundary overwrites pending (last wins).
//    At a frame boundary with o_pending=1: display <= pending, o_pending -> 0.
//    i_load coincident with a boundary: i_digits goes straight to display, o_pending stays 0.
//  - Invalid nibble (>9): driven as 4'hF; the SN74145 outputs nothing for codes 10-15. o_cs and o_dig_n behave normally.
//  - i_en low in any state: next cycle IDLE, outputs blanked, index=0.
//    Pending and display registers are held; o_frame_done is not pulsed. Re-enable restarts at BLANK of digit 0.
//  - i_rst mid-frame overrides everything and returns to the reset values above.
// CONFIGURATION
//  Macro SN74145_SCAN_LZB_EN (leading-zero blanking):
//  - Defined: a digit is driven as 4'hF (o_cs=1, select still asserted) when it and every higher digit are 0.
//    Digit 0 is never blanked.
//  - Undefined: all nibbles are displayed as stored, zeros included.
// STRUCTURE
//  - Package sn74145_pkg: state enum {IDLE,BLANK,ON}, localparam BCD_BLANK=4'hF, localparam BCD_MAX=4'd9.
//  - Sub-module scan_tick_gen: loadable down-counter, reloaded with BLANK_CYC or DWELL_CYC on each state entry; emits a terminal-count pulse.
//    Top holds the FSM, index, registers and output muxing.
// TESTING (N_DIGITS=4, DWELL_CYC=4, BLANK_CYC=2)
//  1. i_rst=1 for 2 cycles -> code 4'hF, o_cs=0, o_dig_n=4'b1111, o_pending=0, o_frame_done=0.
//  2. Load 16'h1234, then i_en=1 -> 2 dark cycles, then code 4 with o_dig_n=1110 for 4 cycles, then 3/1101, 2/1011, 1/0111.
//     o_frame_done pulses every 24 cycles.
//  3. Mid-frame load 16'h5678 -> o_pending=1, display keeps 1234 until o_frame_done.
//     Next frame's digit 0 shows 8, o_pending=0. Load on the boundary cycle -> applied immediately, o_pending stays 0.
//  4. Load 16'h12A4 -> digit 1 drives 4'hF with o_dig_n=1101 and o_cs=1; other digits are unaffected.
//  5. i_en=0 during ON of digit 2 -> next cycle outputs blanked, no frame_done pulse.
//     i_en=1 again -> restarts with BLANK, then digit 0.
//  6. SN74145_SCAN_LZB_EN defined:
//     16'h0070 -> digits 3,2 show 4'hF, digit 1 shows 7, digit 0 shows 0.
//     16'h0000 -> only digit 0 shows 0.

Source files
------------

// File: rtl/sn74145_pkg.sv
// sn74145_pkg
// Shared types and constants for the SN74145 digit scan controller.
// Contents: scan FSM state enum, blank/max BCD codes, nibble-to-code helper.
package sn74145_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  // Codes 10..15 light nothing on the SN74145; normalise them to the
  // blank code so the decoder inputs only ever see 0..9 or F.
  function automatic logic [3:0] bcd_to_code(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_BLANK : nib;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen
// Loadable down-counter timing the BLANK and ON phases of the scan.
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      synchronous reset, active-high (count cleared)
//   i_load     reload the counter with i_load_val this cycle
//   i_load_val reload value (phase length minus one)
//   o_tc       terminal count: high while the count is zero
module scan_tick_gen #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tc
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign o_tc = (cnt_q == '0);

endmodule

// File: rtl/sn74145_scan_ctrl.sv
// sn74145_scan_ctrl
// Time-multiplexed scan controller for one SN74145 BCD-to-decimal decoder
// shared across N_DIGITS digit positions. Each digit gets BLANK_CYC dark
// cycles followed by DWELL_CYC lit cycles; new values are applied only at
// frame boundaries.
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_en                  scan enable (low forces IDLE)
//   i_load, i_digits      load strobe and packed BCD value (digit 0 = LSB)
//   o_a..o_d              BCD code to the decoder (o_a = LSB)
//   o_cs                  high while a digit is lit
//   o_dig_n               one-hot active-low digit select
//   o_pending             a load is waiting for the next frame boundary
//   o_frame_done          one-cycle pulse after the last digit's dwell
// Build option: define SN74145_SCAN_LZB_EN for leading-zero blanking.
//
// state | meaning
// IDLE  | scan stopped, all outputs dark, index held at 0
// BLANK | inter-digit gap, all selects off, code F
// ON    | digit[index] selected and driven
module sn74145_scan_ctrl
  import sn74145_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_digits,
  output logic                  o_a,
  output logic                  o_b,
  output logic                  o_c,
  output logic                  o_d,
  output logic                  o_cs,
  output logic [N_DIGITS-1:0]   o_dig_n,
  output logic                  o_pending,
  output logic                  o_frame_done
);

  localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  scan_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4*N_DIGITS-1:0] display_q, pending_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             tc;
  logic             boundary;
  logic             frame_done_d;

  logic [3:0]          code_d;
  logic                cs_d;
  logic [N_DIGITS-1:0] dig_n_d;
  logic [3:0]          sel_nib;
`ifdef SN74145_SCAN_LZB_EN
  logic                lzb_hit;
`endif

  scan_tick_gen #(.CNT_W(CNT_W)) u_tick (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (cnt_load),
    .i_load_val (cnt_val),
    .o_tc       (tc)
  );

  // Next state. Leaving IDLE counts as a frame boundary too, so a value
  // loaded while stopped is shown from the first frame after enable.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_load     = 1'b0;
    cnt_val      = BLANK_LOAD;
    boundary     = 1'b0;
    frame_done_d = 1'b0;
    if (!i_en) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          idx_d    = '0;
          cnt_load = 1'b1;
          cnt_val  = BLANK_LOAD;
          boundary = 1'b1;
        end
        BLANK: begin
          if (tc) begin
            state_d  = ON;
            cnt_load = 1'b1;
            cnt_val  = DWELL_LOAD;
          end
        end
        ON: begin
          if (tc) begin
            state_d  = BLANK;
            cnt_load = 1'b1;
            cnt_val  = BLANK_LOAD;
            if (idx_q == IDX_LAST) begin
              idx_d        = '0;
              frame_done_d = 1'b1;
              boundary     = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they line
  // up with the state register. display_q only changes when entering
  // BLANK, so it is stable whenever ON is entered.
  always_comb begin
    code_d  = BCD_BLANK;
    cs_d    = 1'b0;
    dig_n_d = '1;
    sel_nib = display_q[{idx_d, 2'b00} +: 4];
`ifdef SN74145_SCAN_LZB_EN
    lzb_hit = (idx_d != '0);
    for (int k = 0; k < N_DIGITS; k++) begin
      if (k >= int'(idx_d) && display_q[4*k +: 4] != 4'd0) lzb_hit = 1'b0;
    end
`endif
    if (state_d == ON) begin
      cs_d           = 1'b1;
      dig_n_d[idx_d] = 1'b0;
      code_d         = bcd_to_code(sel_nib);
`ifdef SN74145_SCAN_LZB_EN
      if (lzb_hit) code_d = BCD_BLANK;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q                <= IDLE;
      idx_q                  <= '0;
      display_q              <= '1;
      pending_q              <= '1;
      {o_d, o_c, o_b, o_a}   <= BCD_BLANK;
      o_cs                   <= 1'b0;
      o_dig_n                <= '1;
      o_pending              <= 1'b0;
      o_frame_done           <= 1'b0;
    end else begin
      state_q                <= state_d;
      idx_q                  <= idx_d;
      {o_d, o_c, o_b, o_a}   <= code_d;
      o_cs                   <= cs_d;
      o_dig_n                <= dig_n_d;
      o_frame_done           <= frame_done_d;
      if (boundary) begin
        // A load landing on the boundary bypasses the pending register.
        if (i_load) begin
          display_q <= i_digits;
        end else if (o_pending) begin
          display_q <= pending_q;
        end
        o_pending <= 1'b0;
      end else if (i_load) begin
        pending_q <= i_digits;
        o_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sn74145_scan_ctrl.sv
module tb_sn74145_scan_ctrl;
  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int BK    = 2;
  localparam int FRAME = N * (DW + BK);

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] digits;
  logic        a, b, c, d, cs, pending, frame_done;
  logic [3:0]  dig_n;
  logic [3:0]  code;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] digits;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  assign code = {d, c, b, a};

  sn74145_scan_ctrl #(
    .N_DIGITS (N),
    .DWELL_CYC(DW),
    .BLANK_CYC(BK)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_load      (load),
    .i_digits    (digits),
    .o_a         (a),
    .o_b         (b),
    .o_c         (c),
    .o_d         (d),
    .o_cs        (cs),
    .o_dig_n     (dig_n),
    .o_pending   (pending),
    .o_frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one whole frame cycle by cycle, starting at its first BLANK cycle.
  // Packed compare: {code, cs, dig_n, frame_done, pending}.
  task automatic check_frame(input string name, input logic [15:0] exp, input bit fd0,
                             input bit do_load, input logic [15:0] nd);
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < BK + DW; j++) begin
        logic [3:0] ec;
        logic       ecs;
        logic [3:0] edn;
        logic       efd;
        logic       ep;
        if (j < BK) begin
          ec = 4'hF; ecs = 1'b0; edn = 4'hF;
        end else begin
          ec = exp[4*k +: 4]; ecs = 1'b1; edn = ~(4'b0001 << k);
        end
        efd = fd0 && (k == 0) && (j == 0);
        ep  = do_load && !((k == 0) && (j == 0));
        check($sformatf("%s d%0d c%0d", name, k, j),
              {21'b0, code, cs, dig_n, frame_done, pending},
              {21'b0, ec, ecs, edn, efd, ep});
        if (do_load && k == 0 && j == 0) begin
          load = 1'b1; digits = nd;
        end
        tick();
        load = 1'b0;
      end
    end
  endtask

  task automatic wait_fd(input string name);
    int n = 0;
    while (frame_done !== 1'b1 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check(name, {31'b0, frame_done}, 32'd1);
  endtask

  initial begin
    logic [15:0] prev;
    int          hits;

    vecs[0] = '{digits: 16'h5678, exp: 16'h5678};
    vecs[1] = '{digits: 16'h12A4, exp: 16'h12F4};
    vecs[2] = '{digits: 16'h9B0C, exp: 16'h9F0F};
`ifdef SN74145_SCAN_LZB_EN
    vecs[3] = '{digits: 16'h0070, exp: 16'hFF70};
    vecs[4] = '{digits: 16'h0000, exp: 16'hFFF0};
`else
    vecs[3] = '{digits: 16'h0070, exp: 16'h0070};
    vecs[4] = '{digits: 16'h0000, exp: 16'h0000};
`endif
    vecs[5] = '{digits: 16'h9087, exp: 16'h9087};

    rst = 1'b1; en = 1'b0; load = 1'b0; digits = 16'h0;
    tick();
    tick();
    check("reset", {21'b0, code, cs, dig_n, frame_done, pending}, {21'b0, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0});
    rst = 1'b0;

    // load while idle, then enable
    load = 1'b1; digits = 16'h1234;
    tick();
    load = 1'b0;
    check("idle_load", {21'b0, code, cs, dig_n, frame_done, pending}, {21'b0, 4'hF, 1'b0, 4'hF, 1'b0, 1'b1});
    en = 1'b1;
    tick();
    check_frame("f1234", 16'h1234, 1'b0, 1'b0, 16'h0);
    check_frame("f1234b", 16'h1234, 1'b1, 1'b0, 16'h0);

    // table: mid-frame load, old value held, new value next frame
    prev = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      check_frame($sformatf("vec%0d", i), prev, 1'b1, 1'b1, vecs[i].digits);
      prev = vecs[i].exp;
    end
    check_frame("vec_last", prev, 1'b1, 1'b0, 16'h0);

    // load coincident with the frame boundary
    for (int i = 0; i < FRAME - 1; i++) tick();
    load = 1'b1; digits = 16'h4321;
    tick();
    load = 1'b0;
    check_frame("bnd_load", 16'h4321, 1'b1, 1'b0, 16'h0);

    // two loads before the boundary: last one wins
    tick(); tick(); tick();
    load = 1'b1; digits = 16'h1111;
    tick();
    digits = 16'h2222;
    tick();
    load = 1'b0;
    check("last_wins_pend", {31'b0, pending}, 32'd1);
    wait_fd("last_wins_fd");
    check_frame("last_wins", 16'h2222, 1'b1, 1'b0, 16'h0);

    // disable during ON of digit 2
    for (int i = 0; i < 15; i++) tick();
    check("dig2_on", {23'b0, code, cs, dig_n}, {23'b0, 4'h2, 1'b1, 4'b1011});
    en = 1'b0;
    tick();
    check("en_off", {21'b0, code, cs, dig_n, frame_done, pending}, {21'b0, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0});
    hits = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      tick();
      if (frame_done !== 1'b0 || cs !== 1'b0) hits++;
    end
    check("idle_quiet", hits, 0);
    en = 1'b1;
    tick();
    check_frame("reenable", 16'h2222, 1'b0, 1'b0, 16'h0);

    // reset mid-frame with a load pending
    for (int i = 0; i < 7; i++) tick();
    load = 1'b1; digits = 16'h9999;
    tick();
    load = 1'b0;
    check("pre_rst_pend", {31'b0, pending}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_reset", {21'b0, code, cs, dig_n, frame_done, pending}, {21'b0, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0});
    rst = 1'b0;
    tick();
    check_frame("post_rst", 16'hFFFF, 1'b0, 1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
